uram_access_arbiter: RTL and testbench

URAM_ACCESS_ARBITER -- requirements
Module: uram_access_arbiter

---
 rtl/uram_arb_pkg.sv | 41 ++++
 rtl/uram_rr_arb2.sv | 61 ++++++
 rtl/uram_access_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_uram_access_arbiter.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uram_arb_pkg.sv
// -----------------------------------------------------------------------------
// uram_arb_pkg
// Shared definitions for the URAM access arbiter:
//   DATA_WIDTH    - URAM word width (16 bits)
//   READ_LATENCY  - URAM read latency in cycles (2)
//   client_id_e   - client identifier (core / host)
//   arb_state_e   - INIT / RUN state of the optional clear sequencer
//   rd_tag_t      - in-flight read tag {valid, client id}
//   other_client  - returns the opposite client of a 2-client pair
// -----------------------------------------------------------------------------
package uram_arb_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int READ_LATENCY = 2;

    typedef enum logic {
        CLIENT_CORE = 1'b0,
        CLIENT_HOST = 1'b1
    } client_id_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       valid;
        client_id_e id;
    } rd_tag_t;

    function automatic client_id_e other_client(input client_id_e id);
        client_id_e res;
        if (id == CLIENT_CORE) begin
            res = CLIENT_HOST;
        end else begin
            res = CLIENT_CORE;
        end
        return res;
    endfunction

endpackage

// File: rtl/uram_rr_arb2.sv
// -----------------------------------------------------------------------------
// uram_rr_arb2
// Two-way round-robin arbiter for one URAM port. The priority register names
// the client that wins the next contention; every grant (contested or not)
// hands priority to the other client.
// Ports:
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset (priority returns to client 0)
//   req_i    - request vector, bit K = client K
//   gnt_o    - one-hot (or zero) grant vector, combinational
// -----------------------------------------------------------------------------
module uram_rr_arb2
    import uram_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    client_id_e prio_q;
    client_id_e prio_d;

    // Grant selection and next priority
    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        case (req_i)
            2'b01: begin
                gnt_o  = 2'b01;
                prio_d = other_client(CLIENT_CORE);
            end
            2'b10: begin
                gnt_o  = 2'b10;
                prio_d = other_client(CLIENT_HOST);
            end
            2'b11: begin
                if (prio_q == CLIENT_CORE) begin
                    gnt_o = 2'b01;
                end else begin
                    gnt_o = 2'b10;
                end
                prio_d = other_client(prio_q);
            end
            default: begin
                gnt_o  = 2'b00;
                prio_d = prio_q;
            end
        endcase
    end

    // Priority register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= CLIENT_CORE;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/uram_access_arbiter.sv
// -----------------------------------------------------------------------------
// uram_access_arbiter
// Shares one simple-dual-port URAM (one read port, one write port, 2-cycle
// read latency) between two clients: client 0 (core) and client 1 (host).
// Each URAM port has its own round-robin arbiter, so a read from one client
// and a write from the other can both be granted in the same cycle. Read
// responses are routed back through a {valid, client-id} tag pipeline that
// matches the URAM read latency.
//
// Optional feature (macro URAM_INIT_CLEAR_EN): after reset an INIT phase
// writes zero to every URAM address, one per cycle, before arbitration starts.
//
// Ports:
//   clock, reset_n                 - clock, async active-low reset
//   cK_req_valid/ready/wen/addr/data - client K request (K = 0 core, 1 host)
//   cK_rsp_valid/data              - client K read response (data 0 when idle)
//   mem_raddr, mem_dout            - URAM read port
//   mem_wen, mem_waddr, mem_din    - URAM write port
//   init_done                      - memory usable
// -----------------------------------------------------------------------------
module uram_access_arbiter
    import uram_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 14
) (
    input  logic                     clock,
    input  logic                     reset_n,

    input  logic                     c0_req_valid,
    output logic                     c0_req_ready,
    input  logic                     c0_req_wen,
    input  logic [ADDRESS_WIDTH-1:0] c0_req_addr,
    input  logic [DATA_WIDTH-1:0]    c0_req_data,
    output logic                     c0_rsp_valid,
    output logic [DATA_WIDTH-1:0]    c0_rsp_data,

    input  logic                     c1_req_valid,
    output logic                     c1_req_ready,
    input  logic                     c1_req_wen,
    input  logic [ADDRESS_WIDTH-1:0] c1_req_addr,
    input  logic [DATA_WIDTH-1:0]    c1_req_data,
    output logic                     c1_rsp_valid,
    output logic [DATA_WIDTH-1:0]    c1_rsp_data,

    output logic [ADDRESS_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0]    mem_dout,
    output logic                     mem_wen,
    output logic [ADDRESS_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0]    mem_din,

    output logic                     init_done
);

    logic                     run_s;
    logic                     init_active_s;
    logic [ADDRESS_WIDTH-1:0] init_addr_s;

    logic [1:0]               rd_req_s;
    logic [1:0]               wr_req_s;
    logic [1:0]               rd_gnt_s;
    logic [1:0]               wr_gnt_s;

    logic [ADDRESS_WIDTH-1:0] raddr_q;
    logic [ADDRESS_WIDTH-1:0] raddr_d;

    rd_tag_t                  tag_new_s;
    rd_tag_t                  tag_q [READ_LATENCY];

`ifdef URAM_INIT_CLEAR_EN
    localparam logic [ADDRESS_WIDTH-1:0] TOP_ADDR = {ADDRESS_WIDTH{1'b1}};

    arb_state_e               state_q;
    arb_state_e               state_d;
    logic [ADDRESS_WIDTH-1:0] init_cnt_q;
    logic [ADDRESS_WIDTH-1:0] init_cnt_d;

    // Clear sequencer: sweep every address, saturate at the top one, then run
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == TOP_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + ADDRESS_WIDTH'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Clear sequencer state and address counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // The last clear write and init_done share a cycle; grants begin after it.
    assign init_active_s = reset_n & (state_q == ST_INIT);
    assign run_s         = (state_q == ST_RUN);
    assign init_addr_s   = init_cnt_q;
    assign init_done     = run_s | (init_active_s & (init_cnt_q == TOP_ADDR));
`else
    assign init_active_s = 1'b0;
    assign run_s         = reset_n;
    assign init_addr_s   = '0;
    assign init_done     = reset_n;
`endif

    // A client carries one request at a time; wen selects which port it competes on.
    assign rd_req_s = {c1_req_valid & ~c1_req_wen, c0_req_valid & ~c0_req_wen} & {2{run_s}};
    assign wr_req_s = {c1_req_valid &  c1_req_wen, c0_req_valid &  c0_req_wen} & {2{run_s}};

    uram_rr_arb2 u_rd_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req_i   (rd_req_s),
        .gnt_o   (rd_gnt_s)
    );

    uram_rr_arb2 u_wr_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req_i   (wr_req_s),
        .gnt_o   (wr_gnt_s)
    );

    assign c0_req_ready = rd_gnt_s[0] | wr_gnt_s[0];
    assign c1_req_ready = rd_gnt_s[1] | wr_gnt_s[1];

    // Write port: clear sweep during INIT, otherwise the granted write
    always_comb begin
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_din   = '0;
        if (init_active_s) begin
            mem_wen   = 1'b1;
            mem_waddr = init_addr_s;
            mem_din   = '0;
        end else if (wr_gnt_s[0]) begin
            mem_wen   = 1'b1;
            mem_waddr = c0_req_addr;
            mem_din   = c0_req_data;
        end else if (wr_gnt_s[1]) begin
            mem_wen   = 1'b1;
            mem_waddr = c1_req_addr;
            mem_din   = c1_req_data;
        end else begin
            mem_wen   = 1'b0;
        end
    end

    // Read port: granted address, otherwise hold the last one issued
    always_comb begin
        raddr_d = raddr_q;
        if (rd_gnt_s[0]) begin
            raddr_d = c0_req_addr;
        end else if (rd_gnt_s[1]) begin
            raddr_d = c1_req_addr;
        end else begin
            raddr_d = raddr_q;
        end
    end

    assign mem_raddr = raddr_d;

    // Last issued read address
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            raddr_q <= '0;
        end else begin
            raddr_q <= raddr_d;
        end
    end

    // Tag for a read accepted this cycle
    always_comb begin
        tag_new_s.valid = |rd_gnt_s;
        if (rd_gnt_s[1]) begin
            tag_new_s.id = CLIENT_HOST;
        end else begin
            tag_new_s.id = CLIENT_CORE;
        end
    end

    // In-flight read tags, one stage per cycle of URAM latency
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '{valid: 1'b0, id: CLIENT_CORE};
            end
        end else begin
            tag_q[0] <= tag_new_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Route returning URAM data to its requester; zero when no response
    always_comb begin
        c0_rsp_valid = 1'b0;
        c1_rsp_valid = 1'b0;
        c0_rsp_data  = '0;
        c1_rsp_data  = '0;
        if (tag_q[READ_LATENCY-1].valid) begin
            if (tag_q[READ_LATENCY-1].id == CLIENT_CORE) begin
                c0_rsp_valid = 1'b1;
                c0_rsp_data  = mem_dout;
            end else begin
                c1_rsp_valid = 1'b1;
                c1_rsp_data  = mem_dout;
            end
        end else begin
            c0_rsp_valid = 1'b0;
            c1_rsp_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_uram_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uram_access_arbiter
// Self-checking bench for uram_access_arbiter. A read-first, 2-cycle URAM is
// attached to the memory ports. A transaction-level model (per-port "who wins
// next" priority, a reference memory array and a queue of expected responses)
// predicts every output each cycle. Build with +define+URAM_INIT_CLEAR_EN to
// exercise the clear sequencer (ADDRESS_WIDTH=4 in that build).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uram_access_arbiter;

`ifdef URAM_INIT_CLEAR_EN
    localparam int AW      = 4;
    localparam bit INIT_EN = 1'b1;
`else
    localparam int AW      = 8;
    localparam bit INIT_EN = 1'b0;
`endif
    localparam int DEPTH = 1 << AW;
    localparam int VW    = 54 + 2 * AW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          c0_req_valid, c0_req_ready, c0_req_wen, c0_rsp_valid;
    logic [AW-1:0] c0_req_addr;
    logic [15:0]   c0_req_data, c0_rsp_data;
    logic          c1_req_valid, c1_req_ready, c1_req_wen, c1_rsp_valid;
    logic [AW-1:0] c1_req_addr;
    logic [15:0]   c1_req_data, c1_rsp_data;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [15:0]   mem_dout, mem_din;
    logic          mem_wen, init_done;

    always #5 clock = ~clock;

    uram_access_arbiter #(.ADDRESS_WIDTH(AW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .c0_req_valid (c0_req_valid),
        .c0_req_ready (c0_req_ready),
        .c0_req_wen   (c0_req_wen),
        .c0_req_addr  (c0_req_addr),
        .c0_req_data  (c0_req_data),
        .c0_rsp_valid (c0_rsp_valid),
        .c0_rsp_data  (c0_rsp_data),
        .c1_req_valid (c1_req_valid),
        .c1_req_ready (c1_req_ready),
        .c1_req_wen   (c1_req_wen),
        .c1_req_addr  (c1_req_addr),
        .c1_req_data  (c1_req_data),
        .c1_rsp_valid (c1_rsp_valid),
        .c1_rsp_data  (c1_rsp_data),
        .mem_raddr    (mem_raddr),
        .mem_dout     (mem_dout),
        .mem_wen      (mem_wen),
        .mem_waddr    (mem_waddr),
        .mem_din      (mem_din),
        .init_done    (init_done)
    );

    // Attached URAM: read-first, 2-cycle read latency, optional bulk preload
    logic [15:0] uram [DEPTH];
    logic [15:0] dout_p1, dout_p2;
    logic        preload_en;
    always @(posedge clock) begin
        dout_p1 <= uram[mem_raddr];
        dout_p2 <= dout_p1;
        if (preload_en) begin
            for (int i = 0; i < DEPTH; i++) uram[i] <= 16'hA5A5 ^ 16'(i);
        end else if (mem_wen) begin
            uram[mem_waddr] <= mem_din;
        end
    end
    assign mem_dout = dout_p2;

    // Reference model state
    logic [15:0]   ref_mem [DEPTH];
    int            prio_rd, prio_wr;
    bit            q1_v, q2_v;
    int            q1_c, q2_c;
    logic [15:0]   q1_d, q2_d;
    logic [AW-1:0] last_raddr;
    bit            in_init;
    int            init_addr;
    logic          x_rdy0, x_rdy1;

    logic [VW-1:0] obs_vec, exp_vec;
    logic          o_rdy0, o_rdy1, o_rv0, o_rv1, o_wen, o_init;
    logic [15:0]   o_rd0, o_rd1;
    logic [AW-1:0] o_waddr;
    int            checks, failures, cyc;

    task automatic drive(input int k, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [15:0] d);
        if (k == 0) begin
            c0_req_valid = v; c0_req_wen = w; c0_req_addr = a; c0_req_data = d;
        end else begin
            c1_req_valid = v; c1_req_wen = w; c1_req_addr = a; c1_req_data = d;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, '0, 16'h0000);
        drive(1, 1'b0, 1'b0, '0, 16'h0000);
    endtask

    // One clock: sample outputs mid-cycle, predict them from the model, advance.
    task automatic tick();
        int            rwin, wwin;
        logic          e_init, e_rdy0, e_rdy1, e_rv0, e_rv1, e_wen;
        logic [15:0]   e_rd0, e_rd1, e_din;
        logic [AW-1:0] e_waddr;
        @(negedge clock);
        o_rdy0 = c0_req_ready; o_rdy1 = c1_req_ready;
        o_rv0 = c0_rsp_valid;  o_rv1 = c1_rsp_valid;
        o_rd0 = c0_rsp_data;   o_rd1 = c1_rsp_data;
        o_wen = mem_wen;       o_waddr = mem_waddr; o_init = init_done;
        obs_vec = {init_done, c0_req_ready, c1_req_ready, c0_rsp_valid, c1_rsp_valid,
                   c0_rsp_data, c1_rsp_data, mem_wen, mem_waddr & {AW{mem_wen}},
                   mem_din & {16{mem_wen}}, mem_raddr};
        e_init = 1'b0; e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
        e_rd0 = 16'h0; e_rd1 = 16'h0; e_wen = 1'b0; e_waddr = '0; e_din = 16'h0;
        rwin = -1; wwin = -1;
        if (!reset_n) begin
            prio_rd = 0; prio_wr = 0; q1_v = 1'b0; q2_v = 1'b0;
            last_raddr = '0; in_init = INIT_EN; init_addr = 0;
        end else begin
            if (q2_v) begin
                if (q2_c == 0) begin e_rv0 = 1'b1; e_rd0 = q2_d; end
                else begin e_rv1 = 1'b1; e_rd1 = q2_d; end
            end
            if (in_init) begin
                e_init = (init_addr == DEPTH - 1);
                e_wen = 1'b1; e_waddr = AW'(init_addr); e_din = 16'h0;
                ref_mem[init_addr] = 16'h0;
                q2_v = q1_v; q2_c = q1_c; q2_d = q1_d; q1_v = 1'b0;
                if (init_addr == DEPTH - 1) in_init = 1'b0;
                else init_addr++;
            end else begin
                e_init = 1'b1;
                if (c0_req_valid && !c0_req_wen && c1_req_valid && !c1_req_wen) rwin = prio_rd;
                else if (c0_req_valid && !c0_req_wen) rwin = 0;
                else if (c1_req_valid && !c1_req_wen) rwin = 1;
                if (c0_req_valid && c0_req_wen && c1_req_valid && c1_req_wen) wwin = prio_wr;
                else if (c0_req_valid && c0_req_wen) wwin = 0;
                else if (c1_req_valid && c1_req_wen) wwin = 1;
                if (rwin >= 0) prio_rd = 1 - rwin;
                if (wwin >= 0) prio_wr = 1 - wwin;
                e_rdy0 = (rwin == 0) || (wwin == 0);
                e_rdy1 = (rwin == 1) || (wwin == 1);
                if (wwin == 0) begin e_wen = 1'b1; e_waddr = c0_req_addr; e_din = c0_req_data; end
                if (wwin == 1) begin e_wen = 1'b1; e_waddr = c1_req_addr; e_din = c1_req_data; end
                if (rwin == 0) last_raddr = c0_req_addr;
                if (rwin == 1) last_raddr = c1_req_addr;
                q2_v = q1_v; q2_c = q1_c; q2_d = q1_d;
                q1_v = (rwin >= 0); q1_c = rwin; q1_d = ref_mem[last_raddr];
                if (wwin >= 0) ref_mem[e_waddr] = e_din;
            end
        end
        x_rdy0 = e_rdy0; x_rdy1 = e_rdy1;
        exp_vec = {e_init, e_rdy0, e_rdy1, e_rv0, e_rv1, e_rd0, e_rd1,
                   e_wen, e_waddr, e_din, last_raddr};
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_init();
        int guard;
        guard = 0;
        idle();
        while (in_init && guard < DEPTH + 4) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL init_sweep cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
            guard++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        preload_en = 1'b1;
        drive(0, 1'b1, 1'b0, AW'(1), 16'h0000);
        drive(1, 1'b1, 1'b1, AW'(2), 16'h1234);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'hA5A5 ^ 16'(i);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
            checks++;
            if (o_rdy0 !== 1'b0 || o_rdy1 !== 1'b0 || o_init !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready cyc=%0d got=%b%b%b exp=000", cyc, o_rdy0, o_rdy1, o_init);
            end
        end
        preload_en = 1'b0;
        idle();
        reset_n = 1'b1;
    endtask

    task automatic test_init();
`ifdef URAM_INIT_CLEAR_EN
        int writes, first_done;
        writes = 0; first_done = -1;
        drive(0, 1'b1, 1'b0, AW'(3), 16'h0000);
        drive(1, 1'b1, 1'b1, AW'(4), 16'h7777);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL init_vec cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
            checks++;
            if (o_rdy0 !== 1'b0 || o_rdy1 !== 1'b0) begin
                failures++;
                $display("FAIL init_ready cyc=%0d got=%b%b exp=00", cyc, o_rdy0, o_rdy1);
            end
            if (o_wen === 1'b1 && o_waddr === AW'(i)) writes++;
            if (o_init === 1'b1 && first_done < 0) first_done = i;
        end
        checks++;
        if (writes !== DEPTH) begin
            failures++;
            $display("FAIL init_writes got=%0d exp=%0d", writes, DEPTH);
        end
        checks++;
        if (first_done !== DEPTH - 1) begin
            failures++;
            $display("FAIL init_done_cycle got=%0d exp=%0d", first_done, DEPTH - 1);
        end
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            drive(0, 1'b1, 1'b0, AW'(a), 16'h0000);
            tick();
            idle();
            tick();
            tick();
            checks++;
            if (o_rv0 !== 1'b1 || o_rd0 !== 16'h0000) begin
                failures++;
                $display("FAIL init_readback addr=%0d got=%b/%h exp=1/0000", a, o_rv0, o_rd0);
            end
        end
`else
        idle();
        tick();
        checks++;
        if (o_init !== 1'b1) begin
            failures++;
            $display("FAIL init_done_tied got=%b exp=1", o_init);
        end
        drive(0, 1'b1, 1'b0, AW'(0), 16'h0000);
        tick();
        checks++;
        if (o_rdy0 !== 1'b1) begin
            failures++;
            $display("FAIL first_cycle_grant got=%b exp=1", o_rdy0);
        end
        idle();
        tick();
        tick();
`endif
    endtask

    task automatic test_write_read();
        idle();
        drive(0, 1'b1, 1'b1, AW'(5), 16'hBEEF);
        tick();
        checks++;
        if (o_rdy0 !== 1'b1) begin
            failures++;
            $display("FAIL wr_accept got=%b exp=1", o_rdy0);
        end
        idle();
        drive(1, 1'b1, 1'b0, AW'(5), 16'h0000);
        tick();
        checks++;
        if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL rd_issue cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
        end
        idle();
        tick();
        checks++;
        if (o_rv1 !== 1'b0) begin
            failures++;
            $display("FAIL rsp_early got=%b exp=0", o_rv1);
        end
        tick();
        checks++;
        if (o_rv1 !== 1'b1 || o_rd1 !== 16'hBEEF || o_rv0 !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_rsp got=%b/%h c0=%b exp=1/beef c0=0", o_rv1, o_rd1, o_rv0);
        end
    endtask

    task automatic test_rr_reads();
        logic [AW-1:0] a0, a1;
        int            w;
        a0 = AW'($urandom_range(0, 15));
        a1 = AW'($urandom_range(0, 15));
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                drive(0, 1'b1, 1'b0, a0, 16'h0000);
                drive(1, 1'b1, 1'b0, a1, 16'h0000);
            end else begin
                idle();
            end
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL rr_vec cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
            if (i < 8) begin
                w = i % 2;
                checks++;
                if (o_rdy0 !== (w == 0) || o_rdy1 !== (w == 1)) begin
                    failures++;
                    $display("FAIL rr_grant i=%0d got=%b%b exp_client=%0d", i, o_rdy0, o_rdy1, w);
                end
                if (w == 0) a0 = AW'($urandom_range(0, 15));
                else a1 = AW'($urandom_range(0, 15));
            end
            if (i >= 2) begin
                w = (i - 2) % 2;
                checks++;
                if (o_rv0 !== (w == 0) || o_rv1 !== (w == 1)) begin
                    failures++;
                    $display("FAIL rr_rsp i=%0d got=%b%b exp_client=%0d", i, o_rv0, o_rv1, w);
                end
            end
        end
    endtask

    task automatic test_read_first();
        logic [AW-1:0] a;
        a = AW'(16);
        idle();
        drive(1, 1'b1, 1'b1, a, 16'h1111);
        tick();
        idle();
        drive(0, 1'b1, 1'b0, a, 16'h0000);
        drive(1, 1'b1, 1'b1, a, 16'h2222);
        tick();
        checks++;
        if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL rf_dual_grant got=%b%b exp=11", o_rdy0, o_rdy1);
        end
        idle();
        tick();
        tick();
        checks++;
        if (o_rv0 !== 1'b1 || o_rd0 !== 16'h1111) begin
            failures++;
            $display("FAIL rf_old_data got=%b/%h exp=1/1111", o_rv0, o_rd0);
        end
        drive(1, 1'b1, 1'b0, a, 16'h0000);
        tick();
        idle();
        tick();
        tick();
        checks++;
        if (o_rv1 !== 1'b1 || o_rd1 !== 16'h2222) begin
            failures++;
            $display("FAIL rf_new_data got=%b/%h exp=1/2222", o_rv1, o_rd1);
        end
    endtask

    task automatic test_random();
        logic          pv [2];
        logic          pw [2];
        logic [AW-1:0] pa [2];
        logic [15:0]   pd [2];
        for (int k = 0; k < 2; k++) begin
            pv[k] = ($urandom_range(0, 3) != 0); pw[k] = 1'($urandom_range(0, 1));
            pa[k] = AW'($urandom_range(0, 15));  pd[k] = 16'($urandom);
        end
        for (int n = 0; n < 300; n++) begin
            drive(0, pv[0], pw[0], pa[0], pd[0]);
            drive(1, pv[1], pw[1], pa[1], pd[1]);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
            for (int k = 0; k < 2; k++) begin
                if (!pv[k] || (k == 0 ? x_rdy0 : x_rdy1)) begin
                    pv[k] = ($urandom_range(0, 3) != 0); pw[k] = 1'($urandom_range(0, 1));
                    pa[k] = AW'($urandom_range(0, 15));  pd[k] = 16'($urandom);
                end
            end
        end
        idle();
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_mid_reset();
        idle();
        drive(0, 1'b1, 1'b0, AW'(3), 16'h0000);
        tick();
        checks++;
        if (o_rdy0 !== 1'b1) begin
            failures++;
            $display("FAIL mr_accept got=%b exp=1", o_rdy0);
        end
        idle();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL mr_in_reset cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
        reset_n = 1'b1;
        wait_init();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (o_rv0 !== 1'b0 || o_rv1 !== 1'b0) begin
                failures++;
                $display("FAIL mr_stale_rsp cyc=%0d got=%b%b exp=00", cyc, o_rv0, o_rv1);
            end
        end
        drive(0, 1'b1, 1'b0, AW'(6), 16'h0000);
        drive(1, 1'b1, 1'b0, AW'(7), 16'h0000);
        tick();
        checks++;
        if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL mr_pointer got=%b%b exp=10", o_rdy0, o_rdy1);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL mr_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        preload_en = 1'b0;
        reset_n = 1'b0;
        in_init = 1'b0;
        idle();
        test_reset();
        test_init();
        test_write_read();
        test_rr_reads();
        test_read_first();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
